// File: rtl/knob_encoder_controller.sv
// rtl/knob_encoder_controller.sv - quadrature encoder to clamped setting value
module knob_encoder_controller #(
  parameter int                 VALUE_W         = 18,
  parameter logic [VALUE_W-1:0] MAX_VALUE       = 18'h3FFFF,
  parameter logic [VALUE_W-1:0] PRESET          = '0,
  parameter int                 STEP            = 1,
  parameter int                 DEBOUNCE_CYCLES = 1000
`ifdef KNOB_ACCEL_EN
  , parameter int               ACCEL_WINDOW    = 50000
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               knob_a,
  input  logic               knob_b,
  input  logic               knob_btn,
  output logic [VALUE_W-1:0] value,
  output logic               step_pulse,
  output logic               step_dir,
  output logic               at_min,
  output logic               at_max
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       RST_LVL  = 3'b110;
  localparam int               CALC_W   = VALUE_W + 4;

  typedef enum logic [1:0] {
    PH_00   = 2'b00,
    PH_01   = 2'b01,
    PH_10   = 2'b10,
    PH_REST = 2'b11
  } phase_e;

  // Bit order {A, B, btn} throughout the input pipeline.
  logic [2:0]       sync1_q, sync2_q, db_q;
  logic [CNT_W-1:0] cnt_q [3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RST_LVL;
      sync2_q <= RST_LVL;
      db_q    <= RST_LVL;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {knob_a, knob_b, knob_btn};
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_q[i] <= '0;
          db_q[i]  <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  phase_e            state_q, state_d, cw_next, ccw_next;
  logic signed [2:0] q_q, q_d;
  logic              det_cw, det_ccw;

  always_comb begin
    state_d  = phase_e'(db_q[2:1]);
    q_d      = q_q;
    det_cw   = 1'b0;
    det_ccw  = 1'b0;
    cw_next  = PH_REST;
    ccw_next = PH_REST;
    unique case (state_q)
      PH_REST: begin cw_next = PH_10;   ccw_next = PH_01;   end
      PH_10:   begin cw_next = PH_00;   ccw_next = PH_REST; end
      PH_00:   begin cw_next = PH_01;   ccw_next = PH_10;   end
      default: begin cw_next = PH_REST; ccw_next = PH_00;   end
    endcase
    // A full detent is the fourth same-direction quarter, landing on REST.
    if (state_d != state_q) begin
      if (state_d == cw_next) begin
        q_d = q_q + 3'sd1;
        if (state_d == PH_REST) begin
          det_cw = (q_q == 3'sd3);
          q_d    = '0;
        end
      end else if (state_d == ccw_next) begin
        q_d = q_q - 3'sd1;
        if (state_d == PH_REST) begin
          det_ccw = (q_q == -3'sd3);
          q_d     = '0;
        end
      end else begin
        q_d = '0;
      end
    end
  end

  logic               btn_prev_q, load;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               pulse_q, pulse_d, dir_q, dir_d, at_min_q, at_max_q;
  logic [CALC_W-1:0]  step_eff, val_ext, max_ext;

  assign load = db_q[0] & ~btn_prev_q;

`ifdef KNOB_ACCEL_EN
  localparam int             ACC_W   = $clog2(ACCEL_WINDOW + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(ACCEL_WINDOW);
  logic [ACC_W-1:0] acc_cnt_q;
  logic             acc_valid_q, fast;

  assign fast     = acc_valid_q && (acc_cnt_q < ACC_MAX) &&
                    ((det_cw && dir_q) || (det_ccw && !dir_q));
  assign step_eff = fast ? CALC_W'(STEP * 8) : CALC_W'(STEP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt_q   <= '0;
      acc_valid_q <= 1'b0;
    end else if (pulse_d) begin
      acc_cnt_q   <= '0;
      acc_valid_q <= 1'b1;
    end else if (acc_cnt_q != ACC_MAX) begin
      acc_cnt_q <= acc_cnt_q + 1'b1;
    end
  end
`else
  assign step_eff = CALC_W'(STEP);
`endif

  always_comb begin
    val_ext = CALC_W'(value_q);
    max_ext = CALC_W'(MAX_VALUE);
    value_d = value_q;
    pulse_d = 1'b0;
    dir_d   = dir_q;
    // Button load outranks a detent completing in the same cycle.
    if (load) begin
      value_d = PRESET;
    end else if (det_cw) begin
      pulse_d = 1'b1;
      dir_d   = 1'b1;
      value_d = (val_ext + step_eff > max_ext) ? MAX_VALUE : VALUE_W'(val_ext + step_eff);
    end else if (det_ccw) begin
      pulse_d = 1'b1;
      dir_d   = 1'b0;
      value_d = (val_ext < step_eff) ? '0 : VALUE_W'(val_ext - step_eff);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= PH_REST;
      q_q        <= '0;
      btn_prev_q <= 1'b0;
      value_q    <= PRESET;
      pulse_q    <= 1'b0;
      dir_q      <= 1'b0;
      at_min_q   <= (PRESET == '0);
      at_max_q   <= (PRESET == MAX_VALUE);
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      btn_prev_q <= db_q[0];
      value_q    <= value_d;
      pulse_q    <= pulse_d;
      dir_q      <= dir_d;
      at_min_q   <= (value_d == '0);
      at_max_q   <= (value_d == MAX_VALUE);
    end
  end

  assign value      = value_q;
  assign step_pulse = pulse_q;
  assign step_dir   = dir_q;
  assign at_min     = at_min_q;
  assign at_max     = at_max_q;

endmodule

// File: tb/tb_knob_encoder_controller.sv
// tb/tb_knob_encoder_controller.sv - directed and randomized check against a detent-level model
module tb_knob_encoder_controller;
  localparam int VW     = 18;
  localparam int PRESET = 100;
  localparam int MAXV   = 103;
  localparam int STEP   = 1;
  localparam int DEB    = 4;
  localparam int HOLD   = 10;
`ifdef KNOB_ACCEL_EN
  localparam int WIN = 50;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          knob_a = 1'b1, knob_b = 1'b1, knob_btn = 1'b0;
  logic [VW-1:0] value;
  logic          step_pulse, step_dir, at_min, at_max;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int cyc = 0;

  knob_encoder_controller #(
    .VALUE_W(VW), .MAX_VALUE(VW'(MAXV)), .PRESET(VW'(PRESET)), .STEP(STEP),
`ifdef KNOB_ACCEL_EN
    .ACCEL_WINDOW(WIN),
`endif
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .knob_a(knob_a), .knob_b(knob_b), .knob_btn(knob_btn),
    .value(value), .step_pulse(step_pulse), .step_dir(step_dir), .at_min(at_min), .at_max(at_max)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (reset_n && step_pulse === 1'b1) pulses++;

  // Reference model: position along the CW cycle 11,10,00,01 and a plain integer quarter count.
  logic [1:0] ph_tab [4];
  int  m_val = PRESET, m_q = 0, m_pos = 0, m_pulses = 0, m_dir = 0;
  int  m_last_cyc = 0;
  bit  m_has_prev = 0;

  function automatic int pos_of(input logic [1:0] ph);
    for (int i = 0; i < 4; i++) if (ph_tab[i] == ph) return i;
    return 0;
  endfunction

  task automatic model_phase(input logic [1:0] ph, input bit btn_edge);
    int np, d, dir, stp;
    bit det;
    det = 0; dir = 0;
    np = pos_of(ph);
    if (np != m_pos) begin
      d = (np - m_pos + 4) % 4;
      if (d == 1) m_q++;
      else if (d == 3) m_q--;
      else m_q = 0;
      if (np == 0) begin
        if (m_q == 4) begin det = 1; dir = 1; end
        else if (m_q == -4) begin det = 1; dir = 0; end
        m_q = 0;
      end
      m_pos = np;
    end
    if (btn_edge) begin
      m_val = PRESET;
    end else if (det) begin
      stp = STEP;
`ifdef KNOB_ACCEL_EN
      if (m_has_prev && dir == m_dir && (cyc - m_last_cyc) <= WIN) stp = STEP * 8;
      m_has_prev = 1;
      m_last_cyc = cyc;
`endif
      m_pulses++;
      m_dir = dir;
      m_val = dir ? ((m_val + stp > MAXV) ? MAXV : m_val + stp)
                  : ((m_val < stp) ? 0 : m_val - stp);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".value"}, 32'(value), 32'(m_val));
    check({tag, ".pulses"}, 32'(pulses), 32'(m_pulses));
    check({tag, ".step_pulse_low"}, {31'd0, step_pulse}, 32'd0);
    check({tag, ".step_dir"}, {31'd0, step_dir}, 32'(m_dir));
    check({tag, ".at_min"}, {31'd0, at_min}, {31'd0, m_val == 0});
    check({tag, ".at_max"}, {31'd0, at_max}, {31'd0, m_val == MAXV});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_phase(input string tag, input logic [1:0] ph, input int hold);
    {knob_a, knob_b} = ph;
    model_phase(ph, 0);
    wait_cyc(hold);
    check_all(tag);
  endtask

  task automatic detent(input string tag, input bit cw, input int hold);
    for (int k = 1; k <= 4; k++)
      drive_phase(tag, ph_tab[cw ? (k % 4) : ((4 - k) % 4)], hold);
  endtask

  task automatic press(input string tag, input int hold);
    knob_btn = 1'b1;
    m_val = PRESET;
    wait_cyc(hold);
    check_all({tag, ".press"});
    knob_btn = 1'b0;
    wait_cyc(hold);
    check_all({tag, ".release"});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_val = PRESET; m_q = 0; m_pos = 0; m_dir = 0; m_has_prev = 0;
    wait_cyc(3);
  endtask

  initial begin
    int r, len, cw, nsteps;
    ph_tab[0] = 2'b11; ph_tab[1] = 2'b10; ph_tab[2] = 2'b00; ph_tab[3] = 2'b01;

    do_reset();
    check("reset.value", 32'(value), 32'd100);
    check("reset.step_pulse", {31'd0, step_pulse}, 32'd0);
    check("reset.at_min", {31'd0, at_min}, 32'd0);
    check("reset.at_max", {31'd0, at_max}, 32'd0);
    reset_n = 1'b1;
    wait_cyc(HOLD);

    detent("cw1", 1, HOLD);
    check("cw1.value101", 32'(value), 32'd101);
    detent("ccw1", 0, HOLD);
    check("ccw1.value100", 32'(value), 32'd100);

    knob_a = 1'b0; wait_cyc(2); knob_a = 1'b1; wait_cyc(HOLD);
    check_all("glitch");
    drive_phase("partial", 2'b10, HOLD);
    drive_phase("partial", 2'b11, HOLD);
    drive_phase("illegal", 2'b00, HOLD);
    drive_phase("illegal", 2'b01, HOLD);
    drive_phase("illegal", 2'b11, HOLD);

    drive_phase("midrot", 2'b10, HOLD);
    drive_phase("midrot", 2'b00, HOLD);
    do_reset();
    reset_n = 1'b1;
    drive_phase("postrst", 2'b00, HOLD);
    drive_phase("postrst", 2'b01, HOLD);
    drive_phase("postrst", 2'b11, HOLD);

    for (int i = 0; i < 6; i++) detent("clamp_hi", 1, HOLD);
    check("clamp_hi.value", 32'(value), 32'd103);
    check("clamp_hi.at_max", {31'd0, at_max}, 32'd1);

    press("btn", 20);
    check("btn.value", 32'(value), 32'd100);
    detent("pre_coin", 1, HOLD);
    drive_phase("coin", 2'b10, HOLD);
    drive_phase("coin", 2'b00, HOLD);
    drive_phase("coin", 2'b01, HOLD);
    {knob_a, knob_b} = 2'b11;
    knob_btn = 1'b1;
    model_phase(2'b11, 1);
    wait_cyc(20);
    check_all("coin.press");
    check("coin.value", 32'(value), 32'd100);
    knob_btn = 1'b0;
    wait_cyc(20);
    check_all("coin.release");

    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        len = $urandom_range(1, DEB - 1);
        if ($urandom_range(0, 1) == 1) begin
          knob_a = ~knob_a; wait_cyc(len); knob_a = ~knob_a;
        end else begin
          knob_b = ~knob_b; wait_cyc(len); knob_b = ~knob_b;
        end
        wait_cyc(HOLD);
        check_all("rnd.glitch");
      end else if (r == 1) begin
        press("rnd.btn", 12);
      end else if (r == 2) begin
        drive_phase("rnd.illegal", {knob_a, knob_b} ^ 2'b11, HOLD);
      end else begin
        cw = $urandom_range(0, 1);
        nsteps = $urandom_range(1, 5);
        for (int k = 0; k < nsteps; k++)
          drive_phase("rnd.step", ph_tab[(pos_of({knob_a, knob_b}) + (cw ? 1 : 3)) % 4], HOLD);
      end
    end
    drive_phase("rnd.home", 2'b00, HOLD);
    drive_phase("rnd.home", 2'b11, HOLD);

    press("to_min", 12);
    for (int i = 0; i < 101; i++) detent("clamp_lo", 0, HOLD);
    check("clamp_lo.value", 32'(value), 32'd0);
    check("clamp_lo.at_min", {31'd0, at_min}, 32'd1);

`ifdef KNOB_ACCEL_EN
    press("accel", 12);
    wait_cyc(60);
    detent("accel1", 0, 8);
    check("accel1.value", 32'(value), 32'd99);
    detent("accel2", 0, 8);
    check("accel2.value", 32'(value), 32'd91);
    wait_cyc(60);
    detent("accel3", 0, 8);
    check("accel3.value", 32'(value), 32'd90);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
